alu_iter: RTL and testbench
===========================

# alu_iter

Parametrised, handshaked successor to the single-cycle datapath ALU. It generalises operand width, adds registered valid/ready flow control, and adds unsigned multiply, divide and remainder, executed iteratively over WIDTH cycles. It sits in the execute stage. Its handshake lets the pipeline stall while a multi-cycle operation is in flight.

## Interface
Parameters:
- WIDTH, 32: operand and result width. Must be a power of two, at least 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and opcode are presented.
- in_ready  out  1  block can accept an operation this cycle.
- alu_op  in  4  opcode (alu_op_e).
- a, b  in  WIDTH  operands.
- out_valid  out  1  result and zero are valid.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  registered result.
- zero  out  1  registered; 1 when result equals 0.

## Operation
- Opcodes:
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 NOT: ~a.
  - 3 SLL: a<<b[SH-1:0].
  - 4 SRL: logical a>>b[SH-1:0].
  - 5 AND.
  - 6 OR.
  - 7 SLTU: 1 if a<b unsigned, else 0.
  - 8 MUL: low WIDTH bits of a*b.
  - 9 DIVU.
  - 10 REMU.
  - 11–15: treated as ADD.
- SH = $clog2(WIDTH). Shift amounts use only the low SH bits of b.
- All arithmetic is modulo 2^WIDTH. Carries and overflow are discarded.
- Divide by zero:
  - DIVU returns all-ones.
  - REMU returns a.
  - No exception is raised.
- FSM states:
  - IDLE:
    - Accept on in_valid&&in_ready.
    - Single-cycle op → DONE, with result registered.
    - Ops 8–10 → BUSY, with counter loaded to WIDTH-1.
  - BUSY:
    - One shift-add (MUL) or restoring-subtract (DIVU/REMU) step per cycle.
    - Counter decrements each cycle.
    - At counter==0, result is registered → DONE.
  - DONE:
    - result and zero are held stable while out_ready is 0.
    - On out_ready, go to IDLE, or accept a new op the same cycle.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from out_ready; it is permitted.
- alu_op, a and b are sampled only on the accept cycle. Later changes on these inputs have no effect.
- zero is registered together with result.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, zero 0, in_ready 1, counter 0.
- Op accepted in cycle N:
  - Single-cycle op: out_valid is high from cycle N+1.
  - MUL/DIVU/REMU: out_valid is high from cycle N+1+WIDTH.
- in_ready is 0 throughout BUSY.
- Sustained back-to-back single-cycle ops with out_ready held at 1 run at 1 op/cycle.
- Simultaneous out_ready and in_valid in DONE: the old result is consumed and the new op is accepted in that same cycle. out_valid stays high only if the new op is single-cycle.
- Reset asserted in any state, including mid-BUSY:
  - The next cycle shows the full reset values.
  - The partial operation is discarded.
  - No result is ever presented for it.
- Reset has priority over a simultaneous accept.

## Configuration
- ALU_MULDIV_EN defined:
  - Opcodes 8–10 are implemented as specified.
  - BUSY state and the iterative datapath are present.
- ALU_MULDIV_EN undefined:
  - Iterative datapath and BUSY state are not compiled in.
  - Opcodes 8–10 behave as ADD, with single-cycle latency.
  - in_ready = IDLE || (DONE && out_ready) still holds.

## Structure
- Package alu_pkg holds:
  - alu_op_e: 4-bit enum of the opcodes above.
  - State enum: IDLE, BUSY, DONE.
  - Helper constant for the shift-amount width.
- Sub-module alu_muldiv_iter holds the shift-add multiplier and restoring divider:
  - Ports: clk, reset, start, op, a, b, done, result.
  - It exists only under ALU_MULDIV_EN.
  - The top-level FSM owns the handshake.

## Test plan
All scenarios use WIDTH=32.
- ADD a=0xFFFFFFFF, b=1, accepted at cycle N → result 0, zero 1, out_valid at N+1.
- SLL a=1, b=33 → result 2. SRL a=0x80000000, b=31 → result 1. SLTU a=5, b=0xFFFFFFFF → result 1.
- MUL a=0x00010000, b=0x00010000 → result 0, zero 1, out_valid at N+33, in_ready 0 during cycles N+1..N+32.
- DIVU 100/7 → 14. REMU 100/7 → 2. DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5.
- Back-pressure:
  - Hold out_ready low 3 cycles in DONE → result and zero stay stable.
  - Then assert out_ready together with in_valid (AND 0xF0, 0x3C) → new op accepted that cycle; result 0x30 on the next cycle.
- Reset asserted 10 cycles into a DIVU → next cycle out_valid 0, in_ready 1, result 0. A following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg - shared types and helpers for the iterative execute-stage ALU.
//
// Contents:
//   alu_op_e         4-bit opcode encoding (codes 11-15 are unassigned and execute as ADD)
//   alu_state_e      handshake FSM states of alu_iter
//   ALU_DEFAULT_WIDTH default operand width
//   alu_sh_width()   shift-amount width for a given operand width
package alu_pkg;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpNot  = 4'd2,
        OpSll  = 4'd3,
        OpSrl  = 4'd4,
        OpAnd  = 4'd5,
        OpOr   = 4'd6,
        OpSltu = 4'd7,
        OpMul  = 4'd8,
        OpDivu = 4'd9,
        OpRemu = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } alu_state_e;

    localparam int unsigned ALU_DEFAULT_WIDTH = 32;

    // Number of low bits of b that form a shift amount.
    function automatic int unsigned alu_sh_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter - iterative unsigned multiplier / restoring divider.
//
// One step per cycle, WIDTH steps per operation. Only instantiated when
// ALU_MULDIV_EN is defined.
//
// Ports:
//   clk     clock
//   reset   synchronous active-high reset; aborts any operation in flight
//   start   load operands and begin (only issued while idle)
//   op      OpMul, OpDivu or OpRemu
//   a, b    operands (multiplicand/multiplier, dividend/divisor)
//   done    high in the cycle of the final step
//   result  valid while done; combinational from the final step
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned SH = alu_sh_width(WIDTH);

    logic             busy_q, busy_d;
    logic [SH-1:0]    cnt_q, cnt_d;
    alu_op_e          op_q, op_d;
    // acc: product accumulator (MUL) or partial remainder (DIV/REM).
    // opa: multiplier shifting right (MUL) or dividend/quotient shifting left (DIV/REM).
    // opb: multiplicand shifting left (MUL) or divisor (DIV/REM).
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;

    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;

    // Single step of both algorithms. A zero divisor needs no special case:
    // every trial subtract succeeds (quotient all-ones) and the remainder
    // simply collects the dividend bits, ending equal to a.
    always_comb begin
        mul_acc = acc_q + (opa_q[0] ? opb_q : '0);
        rem_sh  = {acc_q, opa_q[WIDTH-1]};
        rem_ge  = rem_sh >= {1'b0, opb_q};
        // True difference is below 2^WIDTH whenever it is used.
        rem_sub = rem_sh[WIDTH-1:0] - opb_q;
        div_rem = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
        div_quo = {opa_q[WIDTH-2:0], rem_ge};
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        acc_d  = acc_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = SH'(WIDTH - 1);
            op_d   = alu_op_e'(op);
            acc_d  = '0;
            opa_d  = (alu_op_e'(op) == OpMul) ? b : a;
            opb_d  = (alu_op_e'(op) == OpMul) ? a : b;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            if (op_q == OpMul) begin
                acc_d = mul_acc;
                opa_d = opa_q >> 1;
                opb_d = opb_q << 1;
            end else begin
                acc_d = div_rem;
                opa_d = div_quo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= OpAdd;
            acc_q  <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            acc_q  <= acc_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
        end
    end

    assign done = busy_q && (cnt_q == '0);

    always_comb begin
        unique case (op_q)
            OpMul:   result = mul_acc;
            OpDivu:  result = div_quo;
            default: result = div_rem;
        endcase
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter - handshaked execute-stage ALU with optional iterative MUL/DIVU/REMU.
//
// Build option: define ALU_MULDIV_EN to include the iterative multiply/divide
// datapath and the BUSY state. Without it, opcodes 8-10 execute as ADD.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset
//   in_valid   operation presented on alu_op/a/b
//   in_ready   operation can be accepted this cycle (combinational from out_ready)
//   alu_op     opcode, see alu_pkg::alu_op_e
//   a, b       operands
//   out_valid  result/zero valid
//   out_ready  consumer takes the result this cycle
//   result     registered result
//   zero       registered, high when result is 0
module alu_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int unsigned SH = alu_sh_width(WIDTH);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             accept;
    logic [WIDTH-1:0] single_res;
    alu_op_e          op;

    assign op = alu_op_e'(alu_op);

    // Single-cycle datapath; unassigned codes (and 8-10 without muldiv) add.
    always_comb begin
        case (op)
            OpSub:   single_res = a - b;
            OpNot:   single_res = ~a;
            OpSll:   single_res = a << b[SH-1:0];
            OpSrl:   single_res = a >> b[SH-1:0];
            OpAnd:   single_res = a & b;
            OpOr:    single_res = a | b;
            OpSltu:  single_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: single_res = a + b;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic             op_multi;
    logic             start;
    logic             md_done;
    logic [WIDTH-1:0] md_result;

    assign op_multi = (op == OpMul) || (op == OpDivu) || (op == OpRemu);

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (alu_op),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .result (md_result)
    );
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef ALU_MULDIV_EN
        start    = 1'b0;
`endif
        // DONE with out_ready lets a new op in on the same cycle the old
        // result leaves, giving one op per cycle for single-cycle ops.
        in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
        accept   = in_valid && in_ready;
        case (state_q)
            StIdle, StDone: begin
                if ((state_q == StDone) && out_ready) begin
                    state_d = StIdle;
                end
                if (accept) begin
`ifdef ALU_MULDIV_EN
                    if (op_multi) begin
                        start   = 1'b1;
                        state_d = StBusy;
                    end else
`endif
                    begin
                        result_d = single_res;
                        zero_d   = (single_res == '0);
                        state_d  = StDone;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            StBusy: begin
                if (md_done) begin
                    result_d = md_result;
                    zero_d   = (md_result == '0);
                    state_d  = StDone;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter - directed self-checking bench for alu_iter (WIDTH=32).
// Expectations for opcodes 8-10 follow the ALU_MULDIV_EN build option.
module tb_alu_iter;

    localparam int unsigned WIDTH = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif
    localparam int MD_LAT = MULDIV ? 33 : 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int n_tests = 0;
    int n_fail  = 0;

    alu_iter #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op, wait (bounded) for acceptance, then scramble the inputs.
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        alu_op   = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) check_eq("issue_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        alu_op   = 4'hF;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1234_5678;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
        int lat = 1;
        int ready_seen = 0;
        issue(op, x, y);
        while (!out_valid && lat < 200) begin
            if (in_ready) ready_seen++;
            tick();
            lat++;
        end
        check_eq({tag, " latency"}, lat, exp_lat);
        check_eq({tag, " busy_ready"}, ready_seen, 0);
        check_eq({tag, " result"}, result, exp);
        check_eq({tag, " zero"}, {31'b0, zero}, {31'b0, (exp == 32'd0)});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, " drained"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        int seen;
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = 4'd0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        check_eq("rst out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("rst result", result, 32'd0);
        check_eq("rst zero", {31'b0, zero}, 32'd0);
        reset = 1'b0;
        tick();

        // Single-cycle ops.
        run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        run_op("sub", 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1);
        run_op("not", 4'd2, 32'h0F0F_0000, 32'd0, 32'hF0F0_FFFF, 1);
        run_op("sll", 4'd3, 32'd1, 32'd33, 32'd2, 1);
        run_op("srl", 4'd4, 32'h8000_0000, 32'd31, 32'd1, 1);
        run_op("or", 4'd6, 32'hA000_0005, 32'h0500_0050, 32'hA500_0055, 1);
        run_op("sltu_t", 4'd7, 32'd5, 32'hFFFF_FFFF, 32'd1, 1);
        run_op("sltu_f", 4'd7, 32'hFFFF_FFFF, 32'd5, 32'd0, 1);
        run_op("op12_add", 4'd12, 32'd2, 32'd2, 32'd4, 1);

        // Multi-cycle ops (ADD behaviour when the muldiv option is off).
        run_op("mul_zero", 4'd8, 32'h0001_0000, 32'h0001_0000,
               MULDIV ? 32'd0 : 32'h0002_0000, MD_LAT);
        run_op("mul", 4'd8, 32'd12345, 32'd6789, MULDIV ? 32'd83810205 : 32'd19134, MD_LAT);
        run_op("divu", 4'd9, 32'd100, 32'd7, MULDIV ? 32'd14 : 32'd107, MD_LAT);
        run_op("remu", 4'd10, 32'd100, 32'd7, MULDIV ? 32'd2 : 32'd107, MD_LAT);
        run_op("divu_0", 4'd9, 32'd5, 32'd0, MULDIV ? 32'hFFFF_FFFF : 32'd5, MD_LAT);
        run_op("remu_0", 4'd10, 32'd5, 32'd0, 32'd5, MD_LAT);

        // Back-to-back single-cycle ops with out_ready held high.
        out_ready = 1'b1;
        alu_op = 4'd6; a = 32'hF0; b = 32'h0F; in_valid = 1'b1;
        tick();
        check_eq("b2b0 valid", {31'b0, out_valid}, 32'd1);
        check_eq("b2b0 result", result, 32'hFF);
        alu_op = 4'd1; a = 32'd10; b = 32'd3;
        tick();
        check_eq("b2b1 result", result, 32'd7);
        alu_op = 4'd2; a = 32'd0;
        tick();
        check_eq("b2b2 result", result, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        tick();
        check_eq("b2b drained", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Back-pressure: result held, new op offered but not taken.
        issue(4'd1, 32'd10, 32'd3);
        for (int i = 0; i < 3; i++) begin
            alu_op = 4'd0; a = $urandom; b = $urandom; in_valid = 1'b1;
            tick();
            check_eq("bp result", result, 32'd7);
            check_eq("bp valid", {31'b0, out_valid}, 32'd1);
            check_eq("bp in_ready", {31'b0, in_ready}, 32'd0);
        end
        alu_op = 4'd5; a = 32'hF0; b = 32'h3C; out_ready = 1'b1;
        #1;
        check_eq("bp accept ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_eq("bp new valid", {31'b0, out_valid}, 32'd1);
        check_eq("bp new result", result, 32'h30);
        check_eq("bp new zero", {31'b0, zero}, 32'd0);
        tick();
        out_ready = 1'b0;
        check_eq("bp drained", {31'b0, out_valid}, 32'd0);

        // Multi-cycle op accepted from DONE in the same cycle as consumption.
        issue(4'd0, 32'd1, 32'd1);
        alu_op = 4'd8; a = 32'd3; b = 32'd4; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0;
        check_eq("swap valid", {31'b0, out_valid}, MULDIV ? 32'd0 : 32'd1);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check_eq("swap result", result, MULDIV ? 32'd12 : 32'd7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset ten cycles into a divide.
        issue(4'd9, 32'd100, 32'd7);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("mid_rst in_ready", {31'b0, in_ready}, 32'd1);
        check_eq("mid_rst result", result, 32'd0);
        check_eq("mid_rst zero", {31'b0, zero}, 32'd0);
        seen = 0;
        repeat (40) begin
            if (out_valid) seen++;
            tick();
        end
        check_eq("mid_rst no result", seen, 0);
        run_op("post_rst add", 4'd0, 32'd2, 32'd3, 32'd5, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
